// File: rtl/mod_arith_pkg.sv
// Shared constants and the 16-bit carry-lookahead group
// used by the modular add/sub pipeline.
package mod_arith_pkg;

  localparam logic [63:0] MOD_DEFAULT = 64'hFFFF_FFFF_0000_0001;
  localparam int          CLA_GROUP   = 16;
  localparam logic        OP_ADD      = 1'b0;
  localparam logic        OP_SUB      = 1'b1;

  // Returns {carry_out, sum} for one lookahead group.
  function automatic logic [CLA_GROUP:0] cla16(
    input logic [CLA_GROUP-1:0] x,
    input logic [CLA_GROUP-1:0] y,
    input logic                 ci
  );
    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    for (int i = 0; i < CLA_GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[CLA_GROUP], p ^ c[CLA_GROUP-1:0]};
  endfunction

endpackage

// File: rtl/mod_reduce_sel.sv
// Stage-2 select: picks the raw or MOD-corrected value
// so the result lands in [0, MOD).
module mod_reduce_sel
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             op_sub,
  input  logic             raw_neg,
  input  logic [WIDTH-1:0] raw_lo,
  input  logic             alt_neg,
  input  logic [WIDTH-1:0] alt_lo,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = raw_lo;
    unique case (1'b1)
      (op_sub == OP_ADD): res = alt_neg ? raw_lo : alt_lo;
      (op_sub == OP_SUB): res = raw_neg ? alt_lo : raw_lo;
      default:            res = raw_lo;
    endcase
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular adder/subtractor with valid/ready handshake.
// Optional range checker enabled by MOD_ADDSUB_CHK_EN.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(MOD_DEFAULT),
  parameter int               TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_out,
  output logic [TAG_W-1:0] tag_out
`ifdef MOD_ADDSUB_CHK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] raw_lo;
  logic [WIDTH-1:0] mod_op;
  logic [WIDTH-1:0] alt_lo;
  logic [NG:0]      c_raw;
  logic [NG:0]      c_alt;
  logic             raw_neg;
  logic [1:0]       r_hi;
  logic [1:0]       m_hi;
  logic             c_hi;
  logic             alt_neg;

  // a - b is formed as a + ~b + 1
  assign b_op     = op_sub ? ~b_in : b_in;
  assign c_raw[0] = op_sub;

  for (genvar g = 0; g < NG; g++) begin : g_raw
    assign {c_raw[g+1], raw_lo[g*CLA_GROUP +: CLA_GROUP]} =
      cla16(a_in[g*CLA_GROUP +: CLA_GROUP],
            b_op[g*CLA_GROUP +: CLA_GROUP], c_raw[g]);
  end

  assign raw_neg = c_raw[NG] ^ op_sub;

  // add: raw - MOD = raw + ~MOD + 1 ; sub: raw + MOD
  assign mod_op   = op_sub ? MOD : ~MOD;
  assign c_alt[0] = ~op_sub;

  for (genvar g = 0; g < NG; g++) begin : g_alt
    assign {c_alt[g+1], alt_lo[g*CLA_GROUP +: CLA_GROUP]} =
      cla16(raw_lo[g*CLA_GROUP +: CLA_GROUP],
            mod_op[g*CLA_GROUP +: CLA_GROUP], c_alt[g]);
  end

  // Two extension bits: only the sign of alt is kept.
  assign r_hi    = op_sub ? {raw_neg, raw_neg} : {1'b0, raw_neg};
  assign m_hi    = op_sub ? 2'b00 : 2'b11;
  assign c_hi    = (r_hi[0] & m_hi[0]) |
                   ((r_hi[0] ^ m_hi[0]) & c_alt[NG]);
  assign alt_neg = r_hi[1] ^ m_hi[1] ^ c_hi;

  logic             s1_valid;
  logic             s1_op;
  logic             s1_raw_neg;
  logic [WIDTH-1:0] s1_raw_lo;
  logic             s1_alt_neg;
  logic [WIDTH-1:0] s1_alt_lo;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_ready;
  logic             in_fire;
  logic [WIDTH-1:0] sel_res;

  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = rst_n && (!s1_valid || s2_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign res_out   = s2_res;
  assign tag_out   = s2_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_ADD;
      s1_raw_neg <= 1'b0;
      s1_raw_lo  <= '0;
      s1_alt_neg <= 1'b0;
      s1_alt_lo  <= '0;
      s1_tag     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid   <= 1'b1;
        s1_op      <= op_sub;
        s1_raw_neg <= raw_neg;
        s1_raw_lo  <= raw_lo;
        s1_alt_neg <= alt_neg;
        s1_alt_lo  <= alt_lo;
        s1_tag     <= tag_in;
      end else if (s2_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

  mod_reduce_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .op_sub (s1_op),
    .raw_neg(s1_raw_neg),
    .raw_lo (s1_raw_lo),
    .alt_neg(s1_alt_neg),
    .alt_lo (s1_alt_lo),
    .res    (sel_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_tag   <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= sel_res;
        s2_tag <= s1_tag;
      end
    end
  end

`ifdef MOD_ADDSUB_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (in_fire && (a_in >= MOD || b_in >= MOD)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed self-checking bench for mod_addsub_pipe.
// Covers add/sub reduction, stall, streaming and reset.
module tb_mod_addsub_pipe;

  localparam logic [63:0] M = 64'hFFFF_FFFF_0000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [7:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] res_out;
  logic [7:0]  tag_out;
`ifdef MOD_ADDSUB_CHK_EN
  logic        chk_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_addsub_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .tag_in   (tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_out  (res_out),
    .tag_out  (tag_out)
`ifdef MOD_ADDSUB_CHK_EN
    ,
    .chk_err  (chk_err)
`endif
  );

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_sub    = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tag_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || res_out !== 64'd0 || tag_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b res=%h tag=%h want 0/0/0",
               out_valid, res_out, tag_out);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic [7:0] tag,
                       input logic [63:0] exp, input string name);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    op_sub   = sub;
    tag_in   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid=%b want 0", name, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || res_out !== exp || tag_out !== tag) begin
      errors++;
      $display("FAIL %s: valid=%b res=%h tag=%h want 1 %h %h",
               name, out_valid, res_out, tag_out, exp, tag);
    end
  endtask

  task automatic test_add();
    do_op(64'd5, 64'd7, 1'b0, 8'h11, 64'd12, "add_small");
    do_op(M - 64'd1, 64'd2, 1'b0, 8'h12, 64'd1, "add_wrap");
    do_op(M - 64'd1, M - 64'd1, 1'b0, 8'h13,
          64'hFFFF_FFFE_FFFF_FFFF, "add_max");
    do_op(64'd0, M - 64'd1, 1'b0, 8'h14, M - 64'd1, "add_edge");
    do_op(64'd1, M - 64'd1, 1'b0, 8'h15, 64'd0, "add_to_mod");
  endtask

  task automatic test_sub();
    do_op(64'd3, 64'd5, 1'b1, 8'h21,
          64'hFFFF_FFFE_FFFF_FFFF, "sub_borrow");
    do_op(64'd9, 64'd4, 1'b1, 8'h22, 64'd5, "sub_small");
    do_op(64'd0, 64'd0, 1'b1, 8'h23, 64'd0, "sub_zero");
    do_op(64'd0, M - 64'd1, 1'b1, 8'h24, 64'd1, "sub_neg_max");
    do_op(M - 64'd1, 64'd0, 1'b1, 8'h25, M - 64'd1, "sub_pos_max");
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp [4];
    int got;
    exp[0] = 64'd3;
    exp[1] = 64'd0;
    exp[2] = M - 64'd2;
    exp[3] = 64'd100;
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        checks++;
        if (got > 3 || res_out !== exp[got] ||
            tag_out !== 8'(8'h30 + got)) begin
          errors++;
          $display("FAIL b2b_item%0d: res=%h tag=%h want %h %h", got,
                   res_out, tag_out, exp[got & 3], 8'(8'h30 + got));
        end
        got++;
      end
      in_valid = (cyc < 4);
      tag_in   = 8'(8'h30 + cyc);
      unique case (cyc)
        0: begin a_in = 64'd1; b_in = 64'd2; op_sub = 1'b0; end
        1: begin a_in = 64'd4; b_in = 64'd4; op_sub = 1'b1; end
        2: begin a_in = 64'd0; b_in = 64'd2; op_sub = 1'b1; end
        3: begin a_in = 64'd60; b_in = 64'd40; op_sub = 1'b0; end
        default: ;
      endcase
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 4", got);
    end
  endtask

  task automatic test_backpressure();
    int sent;
    int got;
    logic [63:0] held;
    logic acc;
    sent = 0;
    got  = 0;
    held = '0;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 6);
      a_in      = 64'(3 * sent + 1);
      b_in      = 64'(sent);
      op_sub    = 1'b0;
      tag_in    = 8'(sent);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (cyc == 2) held = res_out;
      if (cyc == 3) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL bp_in_ready: in_ready=%b sent=%0d want 0 2",
                   in_ready, sent);
        end
        checks++;
        if (out_valid !== 1'b1 || res_out !== held || res_out !== 64'd1) begin
          errors++;
          $display("FAIL bp_hold: valid=%b res=%h want 1 %h",
                   out_valid, res_out, 64'd1);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (res_out !== 64'(4 * got + 1) || tag_out !== 8'(got)) begin
          errors++;
          $display("FAIL bp_item%0d: res=%h tag=%h want %h %h", got,
                   res_out, tag_out, 64'(4 * got + 1), 8'(got));
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 6 || sent != 6) begin
      errors++;
      $display("FAIL bp_count: got=%0d sent=%0d want 6 6", got, sent);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a_in     = 64'(50 + i);
      b_in     = 64'd1;
      op_sub   = 1'b0;
      tag_in   = 8'(8'h40 + i);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_full: valid=%b in_ready=%b want 1 0",
               out_valid, in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || res_out !== 64'd0 || tag_out !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: valid=%b res=%h tag=%h want 0",
               out_valid, res_out, tag_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ghost: out_valid=%b want 0", out_valid);
    end
    do_op(64'd10, 64'd20, 1'b0, 8'h50, 64'd30, "rst_mid_next");
  endtask

`ifdef MOD_ADDSUB_CHK_EN
  task automatic test_chk();
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_init: got %b want 0", chk_err);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_in     = M;
    b_in     = 64'd0;
    op_sub   = 1'b0;
    tag_in   = 8'h60;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_set: got %b want 1", chk_err);
    end
    do_op(64'd2, 64'd3, 1'b0, 8'h61, 64'd5, "chk_good");
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_sticky: got %b want 1", chk_err);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_clear: got %b want 0", chk_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
`ifdef MOD_ADDSUB_CHK_EN
    test_chk();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
